instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Responder end of the instruction-fetch interface: a word-organised instruction store.
- Answers fetch-stage read requests (enable, byte address) with a registered 32-bit instruction one cycle later.
- Includes a programming port with a small loader FSM. The FSM NOP-fills the array and then accepts a word stream from a testbench or boot loader.
- Sits between the fetch stage and the (optional) boot/program loader.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- NOP_INST, 32'h0000_0013, instruction returned on fault, busy or fill (addi x0,x0,0).

Ports:
- clk  input  1  main clock
- rst  input  1  asynchronous reset, active-high
- i_rd_enable  input  1  fetch read request
- i_addr  input  32  fetch byte address
- o_rd_data  output  32  instruction, valid the cycle after request
- o_rd_valid  output  1  o_rd_data holds a real (non-substituted) response to last request
- o_misaligned  output  1  last request had i_addr[1:0] != 0
- o_out_of_range  output  1  last request fell outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
- o_busy  output  1  loader not in RUN; core must stall fetch
- i_prog_start  input  1  pulse: begin clear+load sequence
- i_prog_valid  input  1  programming word present
- i_prog_data  input  32  programming word
- o_prog_ready  output  1  loader accepts a word this cycle
- i_prog_done  input  1  pulse: end of program stream

Behaviour:
- Reset (async, rst=1):
  - State = RUN; fill/load pointers = 0.
  - o_rd_data = NOP_INST.
  - o_rd_valid, o_misaligned, o_out_of_range, o_busy, o_prog_ready all = 0.
  - Array contents are not reset and are retained.
- Read path (RUN only), registered, latency 1. Cycle N request with i_rd_enable=1 gives the cycle N+1 response:
  - Aligned and in range: o_rd_data = mem[(i_addr-BASE_ADDR)>>2]; o_rd_valid=1; fault flags 0.
  - Misaligned: o_rd_data = NOP_INST; o_rd_valid=0; o_misaligned=1. Out-of-range check is still evaluated independently.
  - Out of range: o_rd_data = NOP_INST; o_rd_valid=0; o_out_of_range=1.
  - Address arithmetic is a 32-bit unsigned subtract. Wrap below BASE_ADDR counts as out of range.
- i_rd_enable=0: o_rd_data holds its previous value; o_rd_valid and both fault flags go to 0 next cycle.
- Reads in CLEAR/LOAD: the next cycle returns o_rd_data=NOP_INST, o_rd_valid=0, flags 0.
- FSM states: RUN, CLEAR, LOAD.
  - RUN → CLEAR on i_prog_start. fill_ptr=0; o_busy=1 from the next cycle.
  - CLEAR: each cycle mem[fill_ptr]=NOP_INST and fill_ptr++. After writing DEPTH_WORDS-1, go to LOAD (exactly DEPTH_WORDS cycles in CLEAR). load_ptr=0.
  - LOAD: o_prog_ready=1 (registered with state). A write occurs when i_prog_valid && o_prog_ready: mem[load_ptr]=i_prog_data, load_ptr++.
  - LOAD → RUN on i_prog_done, or on acceptance of word DEPTH_WORDS-1 (array full). o_prog_ready=0 and o_busy=0 from the next cycle.
- Simultaneous events and boundary cases:
  - i_prog_done with an accepted i_prog_valid in the same cycle: the word is written, then RUN.
  - i_prog_start in CLEAR or LOAD: ignored.
  - i_prog_start together with i_rd_enable in RUN: the read is served normally; CLEAR starts next cycle.
  - i_prog_valid in RUN or CLEAR: ignored, nothing written.
  - Words offered after the array fills: not accepted (ready=0 in RUN).
  - Reset mid-CLEAR or mid-LOAD: immediately RUN. Pointers are cleared. Partially written contents remain.
- No write path exists from the fetch interface.

Test Plan:
- Reset, prog_start, then load 4 words {0x00500093, 0x00108133, 0x0000006F, 0xDEADBEEF} with done on the 4th. Read 0x0,0x4,0x8,0xC on consecutive cycles → same words appear one cycle later with o_rd_valid=1. Read 0x10 → 0x00000013.
- DEPTH_WORDS=16: prog_start → o_busy=1 for exactly 16 CLEAR cycles plus the LOAD duration. Fetch at 0x0 during CLEAR → NOP_INST, o_rd_valid=0.
- Read 0x2 → o_misaligned=1, NOP_INST. Read BASE_ADDR+4*DEPTH_WORDS → o_out_of_range=1, NOP_INST. Read 0x4 → both flags clear and data valid.
- Load 16 words with no done on DEPTH_WORDS=16 → after the 16th accept, o_prog_ready=0 and RUN. A 17th valid word is dropped, and mem[0] is still the first word.
- Assert rst mid-LOAD after 2 words → o_busy=0 immediately. A new prog_start refills to NOP, and the earlier words read back as 0x00000013 after the fresh load of 0 words plus done.
- i_rd_enable toggled 1,0,1 at addresses 0x0, x, 0x4 → data mem[0], held mem[0] with valid=0, then mem[1].

Source files
------------

// File: rtl/instruction_memory.sv
// Word-organised instruction store with a registered fetch read port and a
// loader FSM that NOP-fills the array, then accepts a program word stream.
module instruction_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_enable,
  input  logic [31:0] i_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_misaligned,
  output logic        o_out_of_range,
  output logic        o_busy,
  input  logic        i_prog_start,
  input  logic        i_prog_valid,
  input  logic [31:0] i_prog_data,
  output logic        o_prog_ready,
  input  logic        i_prog_done
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {RUN, CLEAR, LOAD} state_t;

  state_t        state, state_next;
  logic [AW-1:0] fill_ptr, fill_ptr_next;
  logic [AW-1:0] load_ptr, load_ptr_next;
  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [31:0]   wdata_c;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset_c;
  logic          misaligned_c;
  logic          out_of_range_c;
  logic [AW-1:0] raddr_c;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and land out of range.
  assign offset_c       = i_addr - BASE_ADDR;
  assign misaligned_c   = |i_addr[1:0];
  assign out_of_range_c = {1'b0, offset_c} >= SPAN;
  assign raddr_c        = offset_c[AW+1:2];

  // Loader next-state, pointer update and array write port.
  always_comb begin
    state_next    = state;
    fill_ptr_next = fill_ptr;
    load_ptr_next = load_ptr;
    we_c          = 1'b0;
    waddr_c       = fill_ptr;
    wdata_c       = NOP_INST;
    unique case (state)
      RUN: begin
        if (i_prog_start) begin
          state_next    = CLEAR;
          fill_ptr_next = '0;
        end
      end
      CLEAR: begin
        we_c          = 1'b1;
        fill_ptr_next = fill_ptr + 1'b1;
        if (fill_ptr == LAST) begin
          state_next    = LOAD;
          load_ptr_next = '0;
        end
      end
      LOAD: begin
        if (i_prog_valid && o_prog_ready) begin
          we_c          = 1'b1;
          waddr_c       = load_ptr;
          wdata_c       = i_prog_data;
          load_ptr_next = load_ptr + 1'b1;
          if (load_ptr == LAST) state_next = RUN;
        end
        if (i_prog_done) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      fill_ptr     <= '0;
      load_ptr     <= '0;
      o_busy       <= 1'b0;
      o_prog_ready <= 1'b0;
    end else begin
      state        <= state_next;
      fill_ptr     <= fill_ptr_next;
      load_ptr     <= load_ptr_next;
      o_busy       <= (state_next != RUN);
      o_prog_ready <= (state_next == LOAD);
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  // Fetch response: real data only in RUN for aligned, in-range requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data      <= NOP_INST;
      o_rd_valid     <= 1'b0;
      o_misaligned   <= 1'b0;
      o_out_of_range <= 1'b0;
    end else if (!i_rd_enable) begin
      o_rd_valid     <= 1'b0;
      o_misaligned   <= 1'b0;
      o_out_of_range <= 1'b0;
    end else if (state != RUN) begin
      o_rd_data      <= NOP_INST;
      o_rd_valid     <= 1'b0;
      o_misaligned   <= 1'b0;
      o_out_of_range <= 1'b0;
    end else begin
      o_misaligned   <= misaligned_c;
      o_out_of_range <= out_of_range_c;
      if (!misaligned_c && !out_of_range_c) begin
        o_rd_data  <= mem[raddr_c];
        o_rd_valid <= 1'b1;
      end else begin
        o_rd_data  <= NOP_INST;
        o_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory (DEPTH_WORDS=16): directed loads,
// fetches, fault cases, array-full and reset-during-load scenarios.
module tb_instruction_memory;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_enable;
  logic [31:0] addr;
  logic [31:0] rd_data;
  logic        rd_valid, misaligned, out_of_range, busy;
  logic        prog_start, prog_valid, prog_ready, prog_done;
  logic [31:0] prog_data;

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        m;
    logic        o;
  } exp_t;

  exp_t        q[$];
  logic        chk;
  logic        mon_pend;
  logic [31:0] last_data;
  int          n_chk = 0;
  int          n_fail = 0;

  instruction_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .i_rd_enable(rd_enable), .i_addr(addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_misaligned(misaligned), .o_out_of_range(out_of_range),
    .o_busy(busy),
    .i_prog_start(prog_start), .i_prog_valid(prog_valid), .i_prog_data(prog_data),
    .o_prog_ready(prog_ready), .i_prog_done(prog_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the response to each cycle that was flagged for checking.
  always @(posedge clk) begin
    exp_t e;
    mon_pend = chk;
    #1;
    if (mon_pend) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard: response with empty expectation queue");
      end else begin
        e = q.pop_front();
        check("rd_data", rd_data, e.d);
        check("rd_flags", {29'd0, rd_valid, misaligned, out_of_range}, {29'd0, e.v, e.m, e.o});
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic v,
                    input logic m, input logic o);
    @(negedge clk);
    rd_enable = 1'b1; addr = a; chk = 1'b1;
    q.push_back('{d: d, v: v, m: m, o: o});
    last_data = d;
  endtask

  task automatic rd_hold();
    @(negedge clk);
    rd_enable = 1'b0; addr = 32'hFFFF_FFF0; chk = 1'b1;
    q.push_back('{d: last_data, v: 1'b0, m: 1'b0, o: 1'b0});
  endtask

  task automatic rd_idle();
    @(negedge clk);
    rd_enable = 1'b0; chk = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic done);
    @(negedge clk);
    prog_valid = 1'b1; prog_data = d; prog_done = done;
  endtask

  task automatic prog_idle();
    @(negedge clk);
    prog_valid = 1'b0; prog_done = 1'b0; prog_start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 100; k++) begin
      if (prog_ready) break;
      @(negedge clk);
    end
    check("wait_ready", {31'd0, prog_ready}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; rd_enable = 1'b0; addr = '0; chk = 1'b0;
    prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0; prog_done = 1'b0;
    last_data = NOP;
    #12;
    check("reset_rd_data", rd_data, NOP);
    check("reset_flags", {28'd0, rd_valid, misaligned, out_of_range, busy}, 32'd0);
    check("reset_ready", {31'd0, prog_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start programming; fetch during CLEAR; count CLEAR cycles.
    @(negedge clk);
    prog_start = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    rd_enable = 1'b1; addr = 32'h0; chk = 1'b1;
    q.push_back('{d: NOP, v: 1'b0, m: 1'b0, o: 1'b0});
    last_data = NOP;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (prog_ready) break;
      if (busy) n++;
      @(negedge clk);
      if (k == 0) begin rd_enable = 1'b0; chk = 1'b0; end
    end
    check("clear_cycles", 32'(n), 32'd16);
    check("busy_in_load", {31'd0, busy}, 32'd1);

    load_word(32'h0050_0093, 1'b0);
    load_word(32'h0010_8133, 1'b0);
    load_word(32'h0000_006F, 1'b0);
    load_word(32'hDEAD_BEEF, 1'b1);
    prog_idle();
    check("done_busy_ready", {30'd0, busy, prog_ready}, 32'd0);

    // Back-to-back fetches, faults, and enable toggling.
    rd(32'h0,  32'h0050_0093, 1'b1, 1'b0, 1'b0);
    rd(32'h4,  32'h0010_8133, 1'b1, 1'b0, 1'b0);
    rd(32'h8,  32'h0000_006F, 1'b1, 1'b0, 1'b0);
    rd(32'hC,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    rd(32'h10, NOP,           1'b1, 1'b0, 1'b0);
    rd(32'h2,  NOP,           1'b0, 1'b1, 1'b0);
    rd(32'h40, NOP,           1'b0, 1'b0, 1'b1);
    rd(32'h42, NOP,           1'b0, 1'b1, 1'b1);
    rd(32'h4,  32'h0010_8133, 1'b1, 1'b0, 1'b0);
    rd(32'h0,  32'h0050_0093, 1'b1, 1'b0, 1'b0);
    rd_hold();
    rd(32'h4,  32'h0010_8133, 1'b1, 1'b0, 1'b0);
    rd_idle();

    // prog_start with a read in RUN: read served normally.
    @(negedge clk);
    prog_start = 1'b1; rd_enable = 1'b1; addr = 32'h8; chk = 1'b1;
    q.push_back('{d: 32'h0000_006F, v: 1'b1, m: 1'b0, o: 1'b0});
    last_data = 32'h0000_006F;
    @(negedge clk);
    prog_start = 1'b0; rd_enable = 1'b0; chk = 1'b0;
    wait_ready();

    // Fill the whole array without done; ignored start pulse mid-load.
    for (int i = 0; i < 16; i++) begin
      load_word(32'h1000_0000 + 32'(i), 1'b0);
      if (i == 5) begin
        @(negedge clk);
        prog_valid = 1'b0; prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        check("start_ignored_in_load", {30'd0, busy, prog_ready}, 32'd3);
      end
    end
    @(negedge clk);
    check("full_busy_ready", {30'd0, busy, prog_ready}, 32'd0);
    prog_data = 32'hBADB_AD00;
    prog_idle();
    rd(32'h0,  32'h1000_0000, 1'b1, 1'b0, 1'b0);
    rd(32'h3C, 32'h1000_000F, 1'b1, 1'b0, 1'b0);
    rd(32'h18, 32'h1000_0006, 1'b1, 1'b0, 1'b0);
    rd(32'h40, NOP,           1'b0, 1'b0, 1'b1);
    rd_idle();

    // Reset in the middle of LOAD, then refill and load nothing.
    pulse_start();
    wait_ready();
    load_word(32'hAAAA_0001, 1'b0);
    load_word(32'hAAAA_0002, 1'b0);
    @(negedge clk);
    prog_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_load", {29'd0, busy, prog_ready, rd_valid}, 32'd0);
    last_data = NOP;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    wait_ready();
    @(negedge clk);
    prog_done = 1'b1;
    @(negedge clk);
    prog_done = 1'b0;
    check("empty_load_busy", {30'd0, busy, prog_ready}, 32'd0);
    rd(32'h0, NOP, 1'b1, 1'b0, 1'b0);
    rd(32'h4, NOP, 1'b1, 1'b0, 1'b0);
    rd_idle();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
